mem_req_sched: RTL and testbench
================================

# mem_req_sched

Upstream request scheduler for `mem_intf`. It accepts read/write commands from a client over a valid/ready port and buffers them in a small in-order FIFO. It issues them one at a time to `mem_intf` using that block's `req_vld`/`req_rdy` handshake, and returns read data to the client as a one-cycle response pulse. Its memory-side outputs connect port-for-port to `mem_intf`.

## Interface

Parameters:
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `AW`, 4: address width.
- `DW`, 32: data width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_vld` in 1: client command valid.
- `cmd_rnw` in 1: 1 = read, 0 = write.
- `cmd_addr` in AW: command address.
- `cmd_wdata` in DW: write data; ignored for reads.
- `cmd_rdy` out 1: FIFO can accept a command.
- `req_vld` out 1: request to `mem_intf`.
- `req_rnw` out 1: request type to `mem_intf`.
- `req_addr` out AW: request address.
- `wdata` out DW: request write data.
- `req_rdy` in 1: `mem_intf` completes the request this cycle.
- `rdata` in DW: read data; valid in the cycle `req_vld && req_rdy` for a read.
- `rsp_vld` out 1: one-cycle read response pulse.
- `rsp_addr` out AW: address of the responded read.
- `rsp_data` out DW: captured read data.
- `fifo_cnt` out $clog2(DEPTH)+1: current FIFO occupancy.
- `rd_done`, `wr_done` out 8 each: completed read and write counts; each wraps at 255→0.

## Operation

- **Command push:** a command is pushed when `cmd_vld && cmd_rdy` at a rising edge.
  - `cmd_rdy = (fifo_cnt != DEPTH)` (combinational from the registered count).
  - There is no push when full; the client holds the command.
- **FIFO:** circular, with read and write pointers of `log2(DEPTH)` bits that wrap naturally.
  - The count is a separate register.
  - Push and pop on the same edge leave the count unchanged.
  - Pop from empty never occurs.
- **FSM states:** IDLE, REQ, GAP.
  - IDLE: if `fifo_cnt != 0`, pop the head into `req_rnw`/`req_addr`/`wdata` registers, set `req_vld` = 1, and go to REQ. Otherwise stay in IDLE.
  - REQ: `req_vld` = 1, and `req_rnw`/`req_addr`/`wdata` are held stable. On `req_rdy` = 1:
    - set `req_vld` = 0;
    - for a read, load `rsp_data` ← `rdata`, `rsp_addr` ← `req_addr`, and `rsp_vld` = 1;
    - increment `rd_done` or `wr_done`;
    - go to GAP.
    - If `req_rdy` = 0, stay in REQ indefinitely; there is no timeout.
  - GAP: `req_vld` = 0 for one cycle, then go to IDLE. This guarantees `mem_intf` sees `req_vld` low between requests.
- **Response:** `rsp_vld` is high for exactly one cycle per read; there is no backpressure. `rsp_data` and `rsp_addr` hold their value until the next read completes.
- **`req_rdy` outside REQ:** ignored.
- **Ordering:** commands issue strictly in acceptance order; reads and writes are never reordered.
- **Reset** (async assert, synchronous-edge release):
  - state = IDLE, FIFO emptied, so pending commands are discarded;
  - `req_vld`, `req_rnw`, `rsp_vld` = 0;
  - `req_addr`, `wdata`, `rsp_addr`, `rsp_data` = 0;
  - `fifo_cnt`, `rd_done`, `wr_done` = 0;
  - `cmd_rdy` = 1 once `rst` is low.
  - A request in flight is abandoned: `req_vld` drops immediately on `rst` assertion.

## Timing

- **Accept to issue:** a command accepted at edge k into an empty, idle block drives `req_vld` high after edge k+1. The FIFO entry is visible at k+1 and popped in IDLE at that edge.
- **Completion:** completion is the edge m where `req_vld && req_rdy`. `req_vld` is low after m.
  - For a read, `rsp_vld` is high during the cycle after m.
  - Counters update at m.
- **Back-to-back:** the next request asserts `req_vld` after edge m+2 (GAP at m, IDLE pop at m+1 → REQ). This gives exactly two cycles of `req_vld` low between requests.
- **Request throughput:** with `req_rdy` tied high, one request completes every 3 cycles.
- **Full FIFO:** `cmd_rdy` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the IDLE pop.
- **Outputs:** all outputs are registered except `cmd_rdy`.

## Test plan

- **Reset values:** hold `rst` for 2 cycles with `cmd_vld` = 1.
  - During reset, no push and all outputs at reset values.
  - After release, `cmd_rdy` = 1 and `fifo_cnt` = 0.
- **Single write:** write addr 4'h5, data 32'h0000_BEEF, with `req_rdy` pulsed 3 cycles after `req_vld`.
  - `req_vld`/`req_addr`/`wdata` are held stable until `req_rdy`.
  - `wr_done` = 1 and `rsp_vld` never pulses.
- **Write then read:** write 4'hA ← 32'h1234, then read 4'hA, with a model returning stored data.
  - Exactly one `rsp_vld` pulse, carrying `rsp_addr` = 4'hA and `rsp_data` = 32'h1234.
  - Two low cycles of `req_vld` between the two requests.
- **Fill to full:** push 5 commands with `req_rdy` = 0 (DEPTH = 4).
  - One command is popped into REQ and 4 are queued; `fifo_cnt` = 4 and `cmd_rdy` = 0.
  - Release `req_rdy` = 1: all 5 issue in order, and `fifo_cnt` returns to 0.
- **Random traffic:** 11 random writes to addresses 1–15 followed by 11 reads of the same addresses, with random `req_rdy` delays of 0–5 cycles.
  - Every read returns the last value written; the bench must use a reference model.
  - `wr_done` = 11 and `rd_done` = 11.
- **Reset mid-request:** assert `rst` while in REQ with 2 commands queued.
  - `req_vld` drops asynchronously and the FIFO empties.
  - After release, no stale request issues.

Source files
------------

// File: rtl/mem_req_sched.sv
// Purpose : in-order command scheduler feeding mem_intf; buffers client read/write
//           commands in a small FIFO, issues them one at a time, returns read data.
// Latency : accept at edge k -> req_vld high after k+1; read response the cycle after completion.
// Backpressure: cmd_rdy low while the FIFO is full; req_vld held until req_rdy; no rsp backpressure.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cmd_vld/cmd_rdy/cmd_rnw/cmd_addr/cmd_wdata   client command port (valid/ready)
//   req_vld/req_rdy/req_rnw/req_addr/wdata/rdata mem_intf request port
//   rsp_vld/rsp_addr/rsp_data        one-cycle read response, held until next read
//   fifo_cnt, rd_done, wr_done       occupancy and wrapping completion counters

// Generic circular FIFO with a separate occupancy counter.
// Latency : pushed entry visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module mem_req_sched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_dat_o,
    output logic [$clog2(DEPTH):0] cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: emptying the pointers/count discards stale entries.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign cnt_o      = cnt_q;
endmodule

module mem_req_sched #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_vld,
    input  logic                   cmd_rnw,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [DW-1:0]          cmd_wdata,
    output logic                   cmd_rdy,
    output logic                   req_vld,
    output logic                   req_rnw,
    output logic [AW-1:0]          req_addr,
    output logic [DW-1:0]          wdata,
    input  logic                   req_rdy,
    input  logic [DW-1:0]          rdata,
    output logic                   rsp_vld,
    output logic [AW-1:0]          rsp_addr,
    output logic [DW-1:0]          rsp_data,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic [7:0]             rd_done,
    output logic [7:0]             wr_done
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    state_t        state_q;
    cmd_t          push_cmd;
    cmd_t          head_cmd;
    logic          push;
    logic          pop;
    logic [CW-1:0] cnt;

    logic          req_vld_q;
    logic          req_rnw_q;
    logic [AW-1:0] req_addr_q;
    logic [DW-1:0] wdata_q;
    logic          rsp_vld_q;
    logic [AW-1:0] rsp_addr_q;
    logic [DW-1:0] rsp_data_q;
    logic [7:0]    rd_done_q;
    logic [7:0]    wr_done_q;

    always_comb begin
        push_cmd       = '0;
        push_cmd.rnw   = cmd_rnw;
        push_cmd.addr  = cmd_addr;
        push_cmd.wdata = cmd_wdata;
    end

    // Ready comes straight from the registered count, so no path from cmd_vld.
    assign cmd_rdy = (cnt != CW'(DEPTH));
    assign push    = cmd_vld && cmd_rdy;
    // The head is consumed only while idle, which also keeps pop-from-empty impossible.
    assign pop     = (state_q == S_IDLE) && (cnt != '0);

    mem_req_sched_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(cmd_t))
    ) u_cmd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_cmd),
        .pop_i      (pop),
        .head_dat_o (head_cmd),
        .cnt_o      (cnt)
    );

    // Issue FSM. Every memory-side and response output is a register here, so a
    // reset assertion drops req_vld immediately and abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_vld_q  <= 1'b0;
            req_rnw_q  <= 1'b0;
            req_addr_q <= '0;
            wdata_q    <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rd_done_q  <= '0;
            wr_done_q  <= '0;
        end else begin
            // Response is a single-cycle pulse; rsp_addr/rsp_data keep their value.
            rsp_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        req_rnw_q  <= head_cmd.rnw;
                        req_addr_q <= head_cmd.addr;
                        wdata_q    <= head_cmd.wdata;
                        req_vld_q  <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Request fields stay frozen until mem_intf completes; no timeout.
                    if (req_rdy) begin
                        req_vld_q <= 1'b0;
                        if (req_rnw_q) begin
                            rsp_vld_q  <= 1'b1;
                            rsp_addr_q <= req_addr_q;
                            rsp_data_q <= rdata;
                            rd_done_q  <= rd_done_q + 8'd1;
                        end else begin
                            wr_done_q  <= wr_done_q + 8'd1;
                        end
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Guarantees mem_intf sees req_vld low between requests.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    req_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_vld  = req_vld_q;
    assign req_rnw  = req_rnw_q;
    assign req_addr = req_addr_q;
    assign wdata    = wdata_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_addr = rsp_addr_q;
    assign rsp_data = rsp_data_q;
    assign fifo_cnt = cnt;
    assign rd_done  = rd_done_q;
    assign wr_done  = wr_done_q;
endmodule

// File: tb/tb_mem_req_sched.sv
// Purpose : directed + randomized bench for mem_req_sched with a memory responder model.
// Latency : n/a (bench).
// Backpressure: responder holds, delays or immediately grants req_rdy as directed.
module tb_mem_req_sched;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_vld;
    logic          cmd_rnw;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_rdy;
    logic          req_vld;
    logic          req_rnw;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] wdata;
    logic          req_rdy = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rsp_vld;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    rd_done;
    logic [7:0]    wr_done;

    always #5 clk = ~clk;

    mem_req_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_vld   (cmd_vld),
        .cmd_rnw   (cmd_rnw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_rdy   (cmd_rdy),
        .req_vld   (req_vld),
        .req_rnw   (req_rnw),
        .req_addr  (req_addr),
        .wdata     (wdata),
        .req_rdy   (req_rdy),
        .rdata     (rdata),
        .rsp_vld   (rsp_vld),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .fifo_cnt  (fifo_cnt),
        .rd_done   (rd_done),
        .wr_done   (wr_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: commands in acceptance order, with the read data each read
    // must return computed from the writes accepted before it.
    typedef struct {
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          rsp_q[$];
    logic [DW-1:0] ref_mem [16] = '{default: '0};
    logic [DW-1:0] mi_mem  [16] = '{default: '0};
    int            exp_wr  = 0;
    int            exp_rd  = 0;
    int            n_rsp   = 0;
    int            rdy_mode  = 0;   // 0 hold req_rdy low, 1 fixed delay, 2 random 0..5
    int            fixed_dly = 0;

    // mem_intf responder plus request/response monitors, all on the falling edge.
    logic                armed = 1'b0;
    int                  dly = 0;
    logic [AW+DW:0]      held = '0;
    logic                exp_rsp_next = 1'b0;
    logic                prev_vld = 1'b0;
    int                  low_run = 0;
    logic                gap_chk = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            req_rdy      = 1'b0;
            armed        = 1'b0;
            exp_rsp_next = 1'b0;
            gap_chk      = 1'b0;
            low_run      = 0;
            prev_vld     = 1'b0;
            chk("rst_req_vld", req_vld, 0);
            chk("rst_rsp_vld", rsp_vld, 0);
        end else begin
            chk("rsp_vld_timing", rsp_vld, exp_rsp_next);
            if (rsp_vld && exp_rsp_next && rsp_q.size() != 0) begin
                exp_t r;
                r = rsp_q.pop_front();
                chk("rsp_addr", rsp_addr, r.addr);
                chk("rsp_data", rsp_data, r.rdata);
                n_rsp++;
            end
            exp_rsp_next = 1'b0;

            if (req_vld && !prev_vld && gap_chk) begin
                chk("req_gap", low_run, 2);
                gap_chk = 1'b0;
            end
            low_run  = req_vld ? 0 : low_run + 1;
            prev_vld = req_vld;

            req_rdy = 1'b0;
            rdata   = $urandom;
            if (req_vld) begin
                if (!armed) begin
                    armed = 1'b1;
                    held  = {req_rnw, req_addr, wdata};
                    dly   = (rdy_mode == 2) ? $urandom_range(5, 0) :
                            (rdy_mode == 1) ? fixed_dly : 0;
                end else begin
                    chk("req_stable", {req_rnw, req_addr, wdata}, held);
                end
                if (rdy_mode != 0) begin
                    if (dly == 0) begin
                        req_rdy = 1'b1;
                        armed   = 1'b0;
                        chk("req_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("req_rnw", req_rnw, e.rnw);
                            chk("req_addr", req_addr, e.addr);
                            if (!e.rnw) chk("req_wdata", wdata, e.wdata);
                            if (req_rnw) rsp_q.push_back(e);
                        end
                        if (req_rnw) begin
                            rdata        = mi_mem[req_addr];
                            exp_rsp_next = 1'b1;
                        end else begin
                            mi_mem[req_addr] = wdata;
                        end
                        gap_chk = (exp_q.size() != 0);
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic acc;
        exp_t e;
        acc       = 1'b0;
        cmd_vld   = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int t = 0; t < 200 && !acc; t++) begin
            acc = cmd_rdy;
            cyc(1);
        end
        chk("push_accept", acc, 1);
        cmd_vld = 1'b0;
        if (acc) begin
            e.rnw   = rnw;
            e.addr  = a;
            e.wdata = d;
            e.rdata = ref_mem[a];
            if (rnw) begin
                exp_rd++;
            end else begin
                ref_mem[a] = d;
                exp_wr++;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 600 && !ok; t++) begin
            cyc(1);
            ok = (exp_q.size() == 0) && (fifo_cnt == 0) && !req_vld;
        end
        chk("drain_done", ok, 1);
        cyc(3);
    endtask

    initial begin
        logic          stale;
        int            rsp0;
        logic [AW-1:0] addrs [11];

        // Reset values, with a command presented during reset.
        rst       = 1'b1;
        cmd_vld   = 1'b1;
        cmd_rnw   = 1'b0;
        cmd_addr  = 4'h3;
        cmd_wdata = 32'hDEAD_0001;
        cyc(2);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_req_regs", {req_vld, req_rnw, req_addr, wdata}, 0);
        chk("rst_rsp_regs", {rsp_vld, rsp_addr, rsp_data}, 0);
        chk("rst_done_cnts", {rd_done, wr_done}, 0);
        cmd_vld = 1'b0;
        rst     = 1'b0;
        cyc(1);
        chk("post_rst_cmd_rdy", cmd_rdy, 1);
        chk("post_rst_fifo_cnt", fifo_cnt, 0);
        chk("post_rst_req_vld", req_vld, 0);

        // Single write, req_rdy three cycles after req_vld.
        rdy_mode  = 1;
        fixed_dly = 3;
        push(1'b0, 4'h5, 32'h0000_BEEF);
        chk("issue_lat_k", req_vld, 0);
        cyc(1);
        chk("issue_lat_k1", req_vld, 1);
        chk("issue_addr", req_addr, 4'h5);
        chk("issue_wdata", wdata, 32'h0000_BEEF);
        drain();
        chk("single_wr_done", wr_done, 1);
        chk("single_rd_done", rd_done, 0);
        chk("single_no_rsp", n_rsp, 0);

        // Write then read of the same address, back to back.
        fixed_dly = 0;
        rsp0 = n_rsp;
        push(1'b0, 4'hA, 32'h0000_1234);
        push(1'b1, 4'hA, 32'h0);
        drain();
        chk("wr_rd_rsp_count", n_rsp - rsp0, 1);
        chk("wr_rd_rsp_addr", rsp_addr, 4'hA);
        chk("wr_rd_rsp_data", rsp_data, 32'h0000_1234);

        // Fill to full with req_rdy held low.
        rdy_mode = 0;
        push(1'b0, 4'h1, 32'h1111_0001);
        push(1'b1, 4'h1, 32'h0);
        push(1'b0, 4'h2, 32'h2222_0002);
        push(1'b1, 4'h2, 32'h0);
        push(1'b0, 4'h3, 32'h3333_0003);
        chk("full_fifo_cnt", fifo_cnt, 4);
        chk("full_cmd_rdy", cmd_rdy, 0);
        chk("full_req_vld", req_vld, 1);
        cmd_vld  = 1'b1;
        cmd_rnw  = 1'b1;
        cmd_addr = 4'h3;
        cyc(3);
        chk("full_no_push", fifo_cnt, 4);
        rdy_mode = 1;
        push(1'b1, 4'h3, 32'h0);
        drain();
        chk("drained_fifo_cnt", fifo_cnt, 0);
        chk("fill_wr_done", wr_done, exp_wr);
        chk("fill_rd_done", rd_done, exp_rd);

        // Reset while a request is outstanding and two commands are queued.
        rdy_mode = 0;
        push(1'b0, 4'h7, 32'h7777_0007);
        push(1'b0, 4'h8, 32'h8888_0008);
        push(1'b1, 4'h7, 32'h0);
        chk("mid_fifo_cnt", fifo_cnt, 2);
        chk("mid_req_vld", req_vld, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_vld_async", req_vld, 0);
        chk("mid_rst_fifo_cnt", fifo_cnt, 0);
        exp_q.delete();
        rsp_q.delete();
        exp_wr = 0;
        exp_rd = 0;
        cyc(2);
        rst      = 1'b0;
        rdy_mode = 1;
        stale    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (req_vld) stale = 1'b1;
        end
        chk("no_stale_req", stale, 0);
        chk("mid_rst_done_cnts", {rd_done, wr_done}, 0);

        // Random writes then reads of the same addresses, random req_rdy delays.
        rdy_mode = 2;
        rsp0 = n_rsp;
        for (int i = 0; i < 11; i++) begin
            addrs[i] = AW'($urandom_range(15, 1));
            push(1'b0, addrs[i], $urandom);
            cyc($urandom_range(2, 0));
        end
        for (int i = 0; i < 11; i++) begin
            push(1'b1, addrs[i], 32'h0);
            cyc($urandom_range(2, 0));
        end
        drain();
        chk("rand_wr_done", wr_done, 11);
        chk("rand_rd_done", rd_done, 11);
        chk("rand_rsp_count", n_rsp - rsp0, 11);
        chk("rand_last_rsp_addr", rsp_addr, addrs[10]);
        chk("rand_last_rsp_data", rsp_data, ref_mem[addrs[10]]);
        chk("rand_fifo_cnt", fifo_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
